// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared types and constants for the I2C write master
package i2c_master_pkg;

   localparam int BYTE_W = 8;

   // Quarter-phase indices within one SCL bit period
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   typedef enum logic [3:0] {
      IDLE, START, SADDR1, ACK1, REG, ACK2, WAIT_W, DATA1,
      ACK3, RSTART, SADDR2, ACK4, DATA2, ACK5, STOP
   } state_t;

   function automatic logic is_byte_state(input state_t s);
      return (s == SADDR1) || (s == REG) || (s == DATA1) ||
             (s == SADDR2) || (s == DATA2);
   endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - quarter-phase counter for one SCL bit period
module i2c_bit_timer
   import i2c_master_pkg::*;
#(
   parameter int QTR = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic [1:0] q,
   output logic       bit_end
);

   logic [7:0] cnt;
   logic       qtr_end;

   assign qtr_end = (cnt == 8'(QTR - 1));
   assign bit_end = run && qtr_end && (q == Q3);

   // Held at zero while idle so every timed state begins at q0
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt <= '0;
         q   <= Q0;
      end else if (qtr_end) begin
         cnt <= '0;
         q   <= q + 2'd1;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - two-write I2C master: reg write, hold, repeated-start write
module i2c_write_master
   import i2c_master_pkg::*;
#(
   parameter int QTR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              w_en,
   input  logic [BYTE_W-1:0] data,
   input  logic [BYTE_W-1:0] data2,
   input  logic [BYTE_W-1:0] s_addr,
   input  logic [BYTE_W-1:0] s_addr2,
   input  logic [BYTE_W-1:0] r_addr,
   inout  wire               sda,
   output logic              temp,
   output logic              sig
);

   state_t            state;
   state_t            nstate;
   logic [1:0]        q;
   logic              bit_end;
   logic              run;
   logic              scl_hi;
   logic              byte_done;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] sh;
   logic [BYTE_W-1:0] load_byte;
   logic [BYTE_W-1:0] l_sa;
   logic [BYTE_W-1:0] l_ra;
   logic [BYTE_W-1:0] l_d;
   logic [BYTE_W-1:0] l_sa2;
   logic [BYTE_W-1:0] l_d2;
   logic              sda_out;
   logic              sda_oe;

   assign run       = (state != IDLE) && (state != WAIT_W);
   assign scl_hi    = (q == Q2) || (q == Q3);
   assign byte_done = bit_end && (bit_cnt == 3'(BYTE_W - 1));

   i2c_bit_timer #(.QTR(QTR)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .q       (q),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start)     nstate = START;
         START:   if (bit_end)   nstate = SADDR1;
         SADDR1:  if (byte_done) nstate = ACK1;
         ACK1:    if (bit_end)   nstate = REG;
         REG:     if (byte_done) nstate = ACK2;
         ACK2:    if (bit_end)   nstate = WAIT_W;
         WAIT_W:  if (w_en)      nstate = DATA1;
         DATA1:   if (byte_done) nstate = ACK3;
         ACK3:    if (bit_end)   nstate = RSTART;
         RSTART:  if (bit_end)   nstate = SADDR2;
         SADDR2:  if (byte_done) nstate = ACK4;
         ACK4:    if (bit_end)   nstate = DATA2;
         DATA2:   if (byte_done) nstate = ACK5;
         ACK5:    if (bit_end)   nstate = STOP;
         STOP:    if (bit_end)   nstate = IDLE;
         default:                nstate = IDLE;
      endcase
   end

   always_comb begin
      temp    = 1'b1;
      sda_out = 1'b1;
      sda_oe  = 1'b1;
      sig     = 1'b0;
      case (state)
         START: begin
            temp    = (q != Q3);
            sda_out = (q == Q0);
         end
         SADDR1, REG, DATA1, SADDR2, DATA2: begin
            temp    = scl_hi;
            sda_out = sh[BYTE_W-1];
         end
         ACK1, ACK2, ACK3, ACK4, ACK5: begin
            temp   = scl_hi;
            sda_oe = 1'b0;
         end
         WAIT_W: begin
            temp    = 1'b0;
            sda_out = 1'b0;
            sig     = 1'b1;
         end
         RSTART: begin
            temp    = (q == Q1) || (q == Q2);
            sda_out = (q == Q0) || (q == Q1);
         end
         STOP: begin
            temp    = (q != Q0);
            sda_out = scl_hi;
         end
         default: ;
      endcase
   end

   assign sda = sda_oe ? sda_out : 1'bz;

   always_comb begin
      case (nstate)
         REG:     load_byte = l_ra;
         DATA1:   load_byte = l_d;
         SADDR2:  load_byte = l_sa2;
         DATA2:   load_byte = l_d2;
         default: load_byte = l_sa;
      endcase
   end

   // Byte inputs are captured once on leaving IDLE; the shifter reloads on each byte-state entry
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         sh      <= '0;
         l_sa    <= '0;
         l_ra    <= '0;
         l_d     <= '0;
         l_sa2   <= '0;
         l_d2    <= '0;
      end else begin
         if (state == IDLE && nstate == START) begin
            l_sa  <= s_addr;
            l_ra  <= r_addr;
            l_d   <= data;
            l_sa2 <= s_addr2;
            l_d2  <= data2;
         end
         if (nstate != state)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= bit_cnt + 3'd1;
         if (nstate != state && is_byte_state(nstate))
            sh <= load_byte;
         else if (bit_end && is_byte_state(state))
            sh <= {sh[BYTE_W-2:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - bus-level checks of i2c_write_master against a transaction model
module tb_i2c_write_master;
   import i2c_master_pkg::*;

   localparam int QTR_TB   = 3;
   localparam int BIT_CYC  = 4 * QTR_TB;
   localparam int TX_LIMIT = 60 * BIT_CYC;
   localparam logic [10:0] EV_S = 11'h200;
   localparam logic [10:0] EV_P = 11'h400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       w_en = 1'b0;
   logic [7:0] data = '0, data2 = '0, s_addr = '0, s_addr2 = '0, r_addr = '0;
   wire        sda;
   logic       temp, sig;

   int n_chk = 0;
   int n_pass = 0;

   i2c_write_master #(.QTR(QTR_TB)) dut (
      .clk(clk), .rst(rst), .start(start), .w_en(w_en),
      .data(data), .data2(data2), .s_addr(s_addr), .s_addr2(s_addr2), .r_addr(r_addr),
      .sda(sda), .temp(temp), .sig(sig)
   );

   always #5 clk = ~clk;

   // Slave side: pull-up plus an ACK driver chosen per byte from ack_plan
   bit ack_drv = 1'b0;
   assign sda = ack_drv ? 1'b0 : 1'bz;
   pullup (sda);

   // Bus monitor: turns SCL/SDA activity into START/STOP/frame events
   logic [10:0] evq[$];
   logic [10:0] exp_q[$];
   int          per_q[$];
   int          gap_q[$];
   bit          ack_plan[$];
   bit          in_ack = 1'b0;
   bit          mon_en = 1'b0;
   logic        p_scl = 1'b1, p_sda = 1'b1;
   logic [8:0]  fr = '0;
   int          nbits = 0, cyc = 0, last_rise = 0, last_p = -1, n_stop = 0;

   always @(negedge clk) begin
      cyc++;
      if (!mon_en) begin
         nbits   = 0;
         ack_drv = 1'b0;
         in_ack  = 1'b0;
      end else begin
         if (p_scl && temp && p_sda && !sda) begin
            evq.push_back(EV_S);
            nbits = 0;
            if (last_p >= 0) gap_q.push_back(cyc - last_p);
            last_p = -1;
         end else if (p_scl && temp && !p_sda && sda) begin
            evq.push_back(EV_P);
            nbits  = 0;
            last_p = cyc;
            n_stop++;
         end else if (!p_scl && temp) begin
            if (nbits > 0) per_q.push_back(cyc - last_rise);
            last_rise = cyc;
            fr = {fr[7:0], sda};
            nbits++;
            if (nbits == 9) begin
               evq.push_back({2'b00, fr});
               nbits = 0;
            end
         end
         if (!temp && nbits == 8 && !in_ack) begin
            in_ack  = 1'b1;
            ack_drv = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b1;
         end else if (!temp && nbits == 0 && in_ack) begin
            in_ack  = 1'b0;
            ack_drv = 1'b0;
         end
      end
      p_scl = temp;
      p_sda = sda;
   end

   // Expected bus events of one transaction; an ACKed byte reads 0 in its ninth bit
   task automatic model_tx(input logic [7:0] sa, ra, d, sa2, d2, input bit [4:0] ack);
      exp_q.push_back(EV_S);
      exp_q.push_back({2'b00, sa, ~ack[0]});
      exp_q.push_back({2'b00, ra, ~ack[1]});
      exp_q.push_back({2'b00, d, ~ack[2]});
      exp_q.push_back(EV_S);
      exp_q.push_back({2'b00, sa2, ~ack[3]});
      exp_q.push_back({2'b00, d2, ~ack[4]});
      exp_q.push_back(EV_P);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_all();
      evq.delete(); exp_q.delete(); per_q.delete(); gap_q.delete(); ack_plan.delete();
      last_p = -1;
   endtask

   task automatic plan_tx(input bit [4:0] ack);
      for (int i = 0; i < 5; i++) ack_plan.push_back(ack[i]);
      model_tx(s_addr, r_addr, data, s_addr2, data2, ack);
   endtask

   task automatic randomize_bytes();
      s_addr = 8'($urandom); r_addr = 8'($urandom); data = 8'($urandom);
      s_addr2 = 8'($urandom); data2 = 8'($urandom);
   endtask

   task automatic wait_stops(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * TX_LIMIT; i++) begin
         if (n_stop >= target) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mon_en = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_chk++;
         if ({temp, sda, sig} !== 3'b110)
            $display("FAIL reset_idle cyc%0d: temp,sda,sig=%b want 110", i, {temp, sda, sig});
         else n_pass++;
      end
      mon_en = 1'b1;
      tick();
   endtask

   task automatic test_write();
      bit ok;
      bit [4:0] ack;
      clear_all();
      s_addr = 8'hCD; r_addr = 8'h81; data = 8'hB7; s_addr2 = 8'h4E; data2 = 8'h6A;
      w_en = 1'b0;
      ack = 5'($urandom);
      plan_tx(ack);
      start = 1'b1;
      tick();
      start = 1'b0;
      randomize_bytes();
      ok = 1'b0;
      for (int i = 0; i < TX_LIMIT; i++) begin
         if (sig) begin ok = 1'b1; break; end
         tick();
      end
      n_chk++;
      if (!ok) $display("FAIL wait_w_reached: sig=%b want 1", sig); else n_pass++;
      n_chk++;
      if (evq.size() !== 3) $display("FAIL pre_hold_events: got %0d want 3", evq.size());
      else n_pass++;
      for (int i = 0; i < 3 && i < evq.size(); i++) begin
         n_chk++;
         if (evq[i] !== exp_q[i]) $display("FAIL pre_hold_ev%0d: got %h want %h", i, evq[i], exp_q[i]);
         else n_pass++;
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 10) randomize_bytes();
         n_chk++;
         if ({temp, sda, sig} !== 3'b001)
            $display("FAIL hold cyc%0d: temp,sda,sig=%b want 001", i, {temp, sda, sig});
         else n_pass++;
      end
      w_en = 1'b1;
      tick();
      w_en = 1'b0;
      n_chk++;
      if (sig !== 1'b0) $display("FAIL sig_release: got %b want 0", sig); else n_pass++;
      wait_stops(n_stop + 1, ok);
      n_chk++;
      if (!ok) $display("FAIL write_stop_timeout: no STOP seen"); else n_pass++;
      repeat (2 * BIT_CYC) tick();
      n_chk++;
      if (evq.size() !== exp_q.size()) $display("FAIL write_events: got %0d want %0d", evq.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
         n_chk++;
         if (evq[i] !== exp_q[i]) $display("FAIL write_ev%0d: got %h want %h", i, evq[i], exp_q[i]);
         else n_pass++;
      end
      n_chk++;
      if ({temp, sda, sig} !== 3'b110) $display("FAIL write_idle: temp,sda,sig=%b want 110", {temp, sda, sig});
      else n_pass++;
   endtask

   task automatic test_random();
      bit ok;
      for (int t = 0; t < 3; t++) begin
         clear_all();
         randomize_bytes();
         w_en = 1'b1;
         plan_tx(5'($urandom));
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (50 + $urandom_range(0, 200)) tick();
         randomize_bytes();
         wait_stops(n_stop + 1, ok);
         n_chk++;
         if (!ok) $display("FAIL rand%0d_stop_timeout: no STOP seen", t); else n_pass++;
         repeat (2 * BIT_CYC) tick();
         n_chk++;
         if (evq.size() !== exp_q.size()) $display("FAIL rand%0d_events: got %0d want %0d", t, evq.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
            n_chk++;
            if (evq[i] !== exp_q[i]) $display("FAIL rand%0d_ev%0d: got %h want %h", t, i, evq[i], exp_q[i]);
            else n_pass++;
         end
      end
      w_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit quiet;
      int ev0, st0;
      clear_all();
      randomize_bytes();
      w_en = 1'b1;
      plan_tx(5'b11111);
      start = 1'b1;
      tick();
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < TX_LIMIT; i++) begin
         if (evq.size() == 6 && nbits == 3 && !temp) begin ok = 1'b1; break; end
         tick();
      end
      n_chk++;
      if (!ok) $display("FAIL mid_data2_reached: events=%0d bits=%0d", evq.size(), nbits); else n_pass++;
      rst = 1'b1;
      mon_en = 1'b0;
      tick();
      n_chk++;
      if ({temp, sda, sig} !== 3'b110) $display("FAIL mid_reset_out: temp,sda,sig=%b want 110", {temp, sda, sig});
      else n_pass++;
      n_chk++;
      if (dut.state !== IDLE) $display("FAIL mid_reset_state: got %0d want %0d", dut.state, IDLE);
      else n_pass++;
      rst = 1'b0;
      w_en = 1'b0;
      tick();
      mon_en = 1'b1;
      ev0 = evq.size();
      st0 = n_stop;
      quiet = 1'b1;
      for (int i = 0; i < 5 * BIT_CYC; i++) begin
         tick();
         if ({temp, sda, sig} !== 3'b110) quiet = 1'b0;
      end
      n_chk++;
      if (!quiet) $display("FAIL mid_reset_quiet: bus moved after reset, want idle"); else n_pass++;
      n_chk++;
      if (evq.size() !== ev0 || n_stop !== st0)
         $display("FAIL mid_reset_no_stop: events %0d->%0d stops %0d->%0d want unchanged", ev0, evq.size(), st0, n_stop);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int st0;
      clear_all();
      randomize_bytes();
      w_en = 1'b1;
      st0 = n_stop;
      plan_tx(5'($urandom));
      start = 1'b1;
      tick();
      repeat (50) tick();
      randomize_bytes();
      plan_tx(5'($urandom));
      wait_stops(st0 + 2, ok);
      start = 1'b0;
      n_chk++;
      if (!ok) $display("FAIL b2b_stop_timeout: stops=%0d want %0d", n_stop - st0, 2); else n_pass++;
      repeat (2 * BIT_CYC) tick();
      w_en = 1'b0;
      n_chk++;
      if (evq.size() !== exp_q.size()) $display("FAIL b2b_events: got %0d want %0d", evq.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
         n_chk++;
         if (evq[i] !== exp_q[i]) $display("FAIL b2b_ev%0d: got %h want %h", i, evq[i], exp_q[i]);
         else n_pass++;
      end
      // STOP q2..q3, one IDLE cycle, then START q0 before SDA falls
      n_chk++;
      if (gap_q.size() !== 1) $display("FAIL b2b_gap_count: got %0d want 1", gap_q.size());
      else n_pass++;
      for (int i = 0; i < gap_q.size(); i++) begin
         n_chk++;
         if (gap_q[i] !== 3 * QTR_TB + 1) $display("FAIL b2b_gap: got %0d want %0d", gap_q[i], 3 * QTR_TB + 1);
         else n_pass++;
      end
      n_chk++;
      if (per_q.size() !== 80) $display("FAIL bit_period_count: got %0d want 80", per_q.size());
      else n_pass++;
      for (int i = 0; i < per_q.size(); i++) begin
         n_chk++;
         if (per_q[i] !== BIT_CYC) $display("FAIL bit_period%0d: got %0d want %0d", i, per_q[i], BIT_CYC);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
